// File: rtl/ex_result_stage.sv
// Execute-stage result buffer: a 2-entry FIFO of ALU results toward the memory stage,
// plus the architectural Z/N flag register and branch resolution from live ALU status.
module ex_result_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_sum,
  input  logic [1:0]  alu_status,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic        in_setflags,
  input  logic [1:0]  in_branch,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        flag_z,
  output logic        flag_n,
  output logic        br_taken,
  output logic [31:0] br_target
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] sum;
    logic [4:0]  rd;
    logic        regwrite;
  } entry_t;

  state_t state, state_next;
  entry_t head, tail, head_next, tail_next, incoming;
  logic   accept, pop, cond;

  // Flush kills both the incoming transfer and any pop in the same cycle.
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state == ONE) || (state == FULL);
  assign pop       = out_valid & out_ready & ~flush;

  assign incoming.sum      = alu_sum;
  assign incoming.rd       = in_rd;
  assign incoming.regwrite = in_regwrite;

  assign out_sum      = head.sum;
  assign out_rd       = head.rd;
  assign out_regwrite = head.regwrite;

  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          head_next  = incoming;
        end
      end
      ONE: begin
        // Simultaneous accept and pop replaces the head directly, so there is no bubble.
        if (accept && pop) begin
          head_next = incoming;
        end else if (accept) begin
          state_next = FULL;
          tail_next  = incoming;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next = ONE;
          head_next  = tail;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (flush) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
      head     <= head_next;
      tail     <= tail_next;
    end
  end

  // Branch conditions look at the live ALU status, never at the flag register.
  always_comb begin
    cond = 1'b0;
    unique case (in_branch)
      2'b00: cond = 1'b0;
      2'b01: cond = alu_status[0];
      2'b10: cond = ~alu_status[0];
      2'b11: cond = alu_status[1];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      if (accept && in_setflags) begin
        flag_z <= alu_status[0];
        flag_n <= alu_status[1];
      end
      br_taken  <= accept & cond;
      br_target <= (accept && cond) ? in_target : 32'd0;
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: accepted inputs are queued on the input side,
// popped results are compared on the output side; flags/branch/ready are checked directly.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] aluSum;
  logic [1:0]  aluStatus;
  logic [4:0]  inRd;
  logic        inRegwrite;
  logic        inSetflags;
  logic [1:0]  inBranch;
  logic [31:0] inTarget;
  logic        outValid;
  logic        outReady;
  logic [31:0] outSum;
  logic [4:0]  outRd;
  logic        outRegwrite;
  logic        flagZ;
  logic        flagN;
  logic        brTaken;
  logic [31:0] brTarget;

  typedef struct packed {
    logic [31:0] sum;
    logic [4:0]  rd;
    logic        regwrite;
  } expEntry_t;

  expEntry_t expQ[$];
  expEntry_t pushEntry;
  expEntry_t popEntry;
  int vectors = 0;
  int miscompares = 0;

  ex_result_stage dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .alu_sum      (aluSum),
    .alu_status   (aluStatus),
    .in_rd        (inRd),
    .in_regwrite  (inRegwrite),
    .in_setflags  (inSetflags),
    .in_branch    (inBranch),
    .in_target    (inTarget),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_sum      (outSum),
    .out_rd       (outRd),
    .out_regwrite (outRegwrite),
    .flag_z       (flagZ),
    .flag_n       (flagN),
    .br_taken     (brTaken),
    .br_target    (brTarget)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] sum, input logic [1:0] status,
                               input logic [4:0] rd, input logic rw, input logic setflags,
                               input logic [1:0] branch, input logic [31:0] target);
    inValid    = valid;
    aluSum     = sum;
    aluStatus  = status;
    inRd       = rd;
    inRegwrite = rw;
    inSetflags = setflags;
    inBranch   = branch;
    inTarget   = target;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".outValid"},    32'(outValid),    32'd0);
    checkOutput({tag, ".inReady"},     32'(inReady),     32'd1);
    checkOutput({tag, ".outSum"},      outSum,           32'd0);
    checkOutput({tag, ".outRd"},       32'(outRd),       32'd0);
    checkOutput({tag, ".outRegwrite"}, 32'(outRegwrite), 32'd0);
    checkOutput({tag, ".flagZ"},       32'(flagZ),       32'd0);
    checkOutput({tag, ".flagN"},       32'(flagN),       32'd0);
    checkOutput({tag, ".brTaken"},     32'(brTaken),     32'd0);
    checkOutput({tag, ".brTarget"},    brTarget,         32'd0);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput({tag, ".pendingEntries"}, 32'(expQ.size()), 32'd0);
  endtask

  // Input side: every transfer that will be accepted at the coming edge is queued.
  always @(negedge clk) begin
    if (!reset) begin
      if (flush) begin
        expQ.delete();
      end else if (inValid && inReady) begin
        pushEntry.sum      = aluSum;
        pushEntry.rd       = inRd;
        pushEntry.regwrite = inRegwrite;
        expQ.push_back(pushEntry);
      end
    end
  end

  // Output side: every pop the DUT presents is matched against the queue head.
  always @(negedge clk) begin
    if (!reset && outValid && outReady && !flush) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedPop: got sum 0x%0h, expected no entry at %0t", outSum, $time);
      end else begin
        popEntry = expQ.pop_front();
        checkOutput("pop.outSum",      outSum,           popEntry.sum);
        checkOutput("pop.outRd",       32'(outRd),       32'(popEntry.rd));
        checkOutput("pop.outRegwrite", 32'(outRegwrite), 32'(popEntry.regwrite));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    outReady = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    cycle();
    reset = 1'b0;

    // Single entry latency, then the buffer empties again
    outReady = 1'b1;
    applyStimulus(1'b1, 32'h5, 2'b00, 5'd3, 1'b1, 1'b0, 2'b00, 32'h0);
    cycle();
    idle();
    @(negedge clk);
    checkOutput("single.outValid", 32'(outValid), 32'd1);
    checkOutput("single.outSum",   outSum,        32'h5);
    checkOutput("single.outRd",    32'(outRd),    32'd3);
    cycle();
    @(negedge clk);
    checkOutput("single.outValidAfter", 32'(outValid), 32'd0);

    // Taken-if-Z branch with flag update
    cycle();
    applyStimulus(1'b1, 32'h0, 2'b01, 5'd1, 1'b1, 1'b1, 2'b01, 32'h40);
    cycle();
    idle();
    @(negedge clk);
    checkOutput("brz.flagZ",    32'(flagZ),   32'd1);
    checkOutput("brz.flagN",    32'(flagN),   32'd0);
    checkOutput("brz.brTaken",  32'(brTaken), 32'd1);
    checkOutput("brz.brTarget", brTarget,     32'h40);
    cycle();
    @(negedge clk);
    checkOutput("brz.pulseEnd", 32'(brTaken), 32'd0);

    // Taken-if-not-Z from live status, flags untouched without setflags
    cycle();
    applyStimulus(1'b1, 32'h80000000, 2'b10, 5'd2, 1'b1, 1'b0, 2'b10, 32'h100);
    cycle();
    idle();
    @(negedge clk);
    checkOutput("brnz.brTaken",  32'(brTaken), 32'd1);
    checkOutput("brnz.brTarget", brTarget,     32'h100);
    checkOutput("brnz.flagZ",    32'(flagZ),   32'd1);
    checkOutput("brnz.flagN",    32'(flagN),   32'd0);

    // Taken-if-N with N clear: not taken, flags rewritten to zero
    cycle();
    applyStimulus(1'b1, 32'h9, 2'b00, 5'd5, 1'b0, 1'b1, 2'b11, 32'h200);
    cycle();
    idle();
    @(negedge clk);
    checkOutput("brn.brTaken",  32'(brTaken), 32'd0);
    checkOutput("brn.brTarget", brTarget,     32'h0);
    checkOutput("brn.flagZ",    32'(flagZ),   32'd0);
    checkOutput("brn.flagN",    32'(flagN),   32'd0);
    waitDrain("early");

    // Back-pressure: A and B accepted, C held until a slot frees
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h1, 2'b00, 5'd4, 1'b1, 1'b0, 2'b00, 32'h0);
    cycle();
    applyStimulus(1'b1, 32'h2, 2'b00, 5'd4, 1'b1, 1'b0, 2'b00, 32'h0);
    cycle();
    applyStimulus(1'b1, 32'h3, 2'b00, 5'd4, 1'b1, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    checkOutput("bp.inReadyFull", 32'(inReady),  32'd0);
    checkOutput("bp.outValid",    32'(outValid), 32'd1);
    checkOutput("bp.headA",       outSum,        32'h1);
    cycle();
    @(negedge clk);
    checkOutput("bp.inReadyHold", 32'(inReady), 32'd0);
    checkOutput("bp.headStable",  outSum,       32'h1);
    cycle();
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("bp.inReadyAtPop", 32'(inReady), 32'd0);
    cycle();
    @(negedge clk);
    checkOutput("bp.inReadyAfterPop", 32'(inReady), 32'd1);
    cycle();
    idle();
    waitDrain("bp");

    // Flush while FULL with a would-be-taken branch and flag update
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h7, 2'b01, 5'd6, 1'b1, 1'b1, 2'b00, 32'h0);
    cycle();
    applyStimulus(1'b1, 32'h8, 2'b00, 5'd7, 1'b1, 1'b0, 2'b00, 32'h0);
    cycle();
    flush = 1'b1;
    applyStimulus(1'b1, 32'h99, 2'b10, 5'd8, 1'b1, 1'b1, 2'b11, 32'h300);
    @(negedge clk);
    checkOutput("flushFull.inReadyBefore", 32'(inReady), 32'd0);
    cycle();
    flush = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("flushFull.outValid", 32'(outValid), 32'd0);
    checkOutput("flushFull.inReady",  32'(inReady),  32'd1);
    checkOutput("flushFull.brTaken",  32'(brTaken),  32'd0);
    checkOutput("flushFull.flagZ",    32'(flagZ),    32'd1);
    checkOutput("flushFull.flagN",    32'(flagN),    32'd0);

    // Flush in ONE while the input could otherwise be accepted
    cycle();
    applyStimulus(1'b1, 32'h11, 2'b00, 5'd9, 1'b1, 1'b0, 2'b00, 32'h0);
    cycle();
    flush = 1'b1;
    applyStimulus(1'b1, 32'h80000000, 2'b10, 5'd9, 1'b1, 1'b1, 2'b11, 32'h400);
    cycle();
    flush = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("flushOne.outValid", 32'(outValid), 32'd0);
    checkOutput("flushOne.inReady",  32'(inReady),  32'd1);
    checkOutput("flushOne.brTaken",  32'(brTaken),  32'd0);
    checkOutput("flushOne.flagZ",    32'(flagZ),    32'd1);
    checkOutput("flushOne.flagN",    32'(flagN),    32'd0);

    // Asynchronous reset between edges while FULL with a branch pulse active
    cycle();
    applyStimulus(1'b1, 32'h21, 2'b00, 5'd10, 1'b1, 1'b0, 2'b00, 32'h0);
    cycle();
    applyStimulus(1'b1, 32'h22, 2'b11, 5'd11, 1'b1, 1'b1, 2'b01, 32'h500);
    cycle();
    idle();
    @(negedge clk);
    checkOutput("preReset.brTaken",  32'(brTaken), 32'd1);
    checkOutput("preReset.brTarget", brTarget,     32'h500);
    checkOutput("preReset.inReady",  32'(inReady), 32'd0);
    checkOutput("preReset.flagN",    32'(flagN),   32'd1);
    #2;
    reset = 1'b1;
    expQ.delete();
    #1;
    checkResetValues("asyncReset");
    cycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postReset.outValid", 32'(outValid), 32'd0);
    checkOutput("postReset.inReady",  32'(inReady),  32'd1);
    checkOutput("final.pendingEntries", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
